// File: rtl/sreg_mem_wb_ctl_pkg.sv
// Shared RV32I pipeline types: the packed control word carried down the pipe
// and the MEM/WB stage occupancy state.
package rv32i_types;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic       load_regfile;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] regfilemux_sel;
    } rv32i_control_word;

    typedef enum logic [1:0] {
        MWB_EMPTY,
        MWB_FULL,
        MWB_WAIT,   // valid load, response pending
        MWB_DRAIN   // flushed load, response still owed by memory
    } mem_wb_state_e;

endpackage

// File: rtl/sreg_mem_wb_ctl_if.sv
// MEM -> WB stage bundle: incoming slot, data-cache response, flow control
// and the held writeback slot.
interface sreg_mem_wb_ctl_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 21,
    parameter int MASK_W = DATA_W / 8
);
    logic              in_valid;
    logic              in_is_load;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_pc;
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_br_en;
    logic [MASK_W-1:0] in_mem_byte_en;
    logic              stall_i;
    logic              flush_i;
    logic              data_resp;
    logic [DATA_W-1:0] data_rdata;

    logic              out_valid;
    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_br_en;
    logic [MASK_W-1:0] out_mem_byte_en;
    logic              busy_o;
    logic              spurious_resp_o;

    // MEM-stage / hazard-unit side.
    modport master (
        output in_valid, in_is_load, in_alu, in_pc, in_ctrl, in_br_en, in_mem_byte_en,
        output stall_i, flush_i, data_resp, data_rdata,
        input  out_valid, out_alu, out_pc, out_data, out_ctrl, out_br_en, out_mem_byte_en,
        input  busy_o, spurious_resp_o
    );

    // Stage-register side.
    modport slave (
        input  in_valid, in_is_load, in_alu, in_pc, in_ctrl, in_br_en, in_mem_byte_en,
        input  stall_i, flush_i, data_resp, data_rdata,
        output out_valid, out_alu, out_pc, out_data, out_ctrl, out_br_en, out_mem_byte_en,
        output busy_o, spurious_resp_o
    );
endinterface

// File: rtl/sreg_mem_wb_ctl_tracker.sv
// Load-response tracker: keeps a load in the stage until its response lands
// and swallows the response owed to a flushed load.
module mem_resp_tracker
    import rv32i_types::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          accept_i,
    input  logic          valid_i,
    input  logic          is_load_i,
    input  logic          resp_i,
    input  logic          flush_i,
    output mem_wb_state_e state_o,
    output logic          busy_o,
    output logic          cap_bundle_o,
    output logic          cap_data_o,
    output logic          spurious_resp_o
);

    mem_wb_state_e state_q, state_d;

    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        cap_bundle_o    = 1'b0;
        cap_data_o      = 1'b0;
        spurious_resp_o = 1'b0;
        unique case (state_q)
            MWB_EMPTY, MWB_FULL: begin
                spurious_resp_o = resp_i & ~(accept_i & valid_i & is_load_i);
                if (flush_i) begin
                    state_d = MWB_EMPTY;
                end else if (accept_i) begin
                    cap_bundle_o = 1'b1;
                    if (!valid_i) begin
                        state_d = MWB_EMPTY;
                    end else if (!is_load_i || resp_i) begin
                        state_d    = MWB_FULL;
                        cap_data_o = is_load_i & resp_i;
                    end else begin
                        state_d = MWB_WAIT;
                    end
                end
            end
            MWB_WAIT: begin
                // A response wins over stall; paired with a flush it is dropped.
                if (resp_i) begin
                    state_d    = flush_i ? MWB_EMPTY : MWB_FULL;
                    cap_data_o = ~flush_i;
                end else if (flush_i) begin
                    state_d = MWB_DRAIN;
                end
            end
            MWB_DRAIN: begin
                if (resp_i) state_d = MWB_EMPTY;
            end
            default: state_d = MWB_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MWB_EMPTY;
        else        state_q <= state_d;
    end

    assign state_o = state_q;
    assign busy_o  = (state_q == MWB_WAIT) || (state_q == MWB_DRAIN);

endmodule

// File: rtl/sreg_mem_wb_ctl.sv
// MEM/WB stage register with valid, stall, flush and load-response tracking;
// bubbles present a zeroed control word to writeback.
module sreg_mem_wb_ctl
    import rv32i_types::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = $bits(rv32i_control_word),
    parameter int MASK_W = DATA_W / 8
) (
    input logic                clk,
    input logic                rst_n,
    sreg_mem_wb_ctl_if.slave   bus
);

    mem_wb_state_e     state;
    logic              busy, adv, cap_bundle, cap_data;

    logic [DATA_W-1:0] alu_q, pc_q, data_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              br_en_q;
    logic [MASK_W-1:0] byte_en_q;

    assign adv = ~bus.stall_i & ~busy & ~bus.flush_i;

    mem_resp_tracker u_tracker (
        .clk             (clk),
        .rst_n           (rst_n),
        .accept_i        (adv),
        .valid_i         (bus.in_valid),
        .is_load_i       (bus.in_is_load),
        .resp_i          (bus.data_resp),
        .flush_i         (bus.flush_i),
        .state_o         (state),
        .busy_o          (busy),
        .cap_bundle_o    (cap_bundle),
        .cap_data_o      (cap_data),
        .spurious_resp_o (bus.spurious_resp_o)
    );

    // NOTE: payload registers are reset too, so every output reads 0 out of
    // reset rather than X, even though out_valid already masks them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q     <= '0;
            pc_q      <= '0;
            ctrl_q    <= '0;
            br_en_q   <= 1'b0;
            byte_en_q <= '0;
            data_q    <= '0;
        end else begin
            if (cap_bundle) begin
                alu_q     <= bus.in_alu;
                pc_q      <= bus.in_pc;
                ctrl_q    <= bus.in_ctrl;
                br_en_q   <= bus.in_br_en;
                byte_en_q <= bus.in_mem_byte_en;
            end
            if (cap_data) data_q <= bus.data_rdata;
        end
    end

    assign bus.out_valid       = (state == MWB_FULL);
    assign bus.out_alu         = alu_q;
    assign bus.out_pc          = pc_q;
    assign bus.out_data        = data_q;
    assign bus.out_ctrl        = bus.out_valid ? ctrl_q : '0;
    assign bus.out_br_en       = br_en_q;
    assign bus.out_mem_byte_en = byte_en_q;
    assign bus.busy_o          = busy;

endmodule

// File: tb/tb_sreg_mem_wb_ctl.sv
// Directed bench for sreg_mem_wb_ctl: hand-computed expectations for reset,
// non-loads, late/same-cycle loads, flush/drain, stall and spurious responses.
module tb_sreg_mem_wb_ctl;
    import rv32i_types::*;

    localparam int DATA_W = 32;
    localparam int CTRL_W = $bits(rv32i_control_word);
    localparam int MASK_W = DATA_W / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    sreg_mem_wb_ctl_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .MASK_W(MASK_W)) bus ();

    sreg_mem_wb_ctl #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .MASK_W(MASK_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [CTRL_W-1:0] ctrl);
        bus.in_valid       = v;
        bus.in_is_load     = ld;
        bus.in_alu         = alu;
        bus.in_pc          = pc;
        bus.in_ctrl        = ctrl;
        bus.in_br_en       = alu[0];
        bus.in_mem_byte_en = pc[3:0];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"}, bus.out_valid, 0);
        check({tag, ".busy"},  bus.busy_o, 0);
        check({tag, ".alu"},   bus.out_alu, 0);
        check({tag, ".pc"},    bus.out_pc, 0);
        check({tag, ".data"},  bus.out_data, 0);
        check({tag, ".ctrl"},  bus.out_ctrl, 0);
        check({tag, ".br"},    bus.out_br_en, 0);
        check({tag, ".ben"},   bus.out_mem_byte_en, 0);
        check({tag, ".spur"},  bus.spurious_resp_o, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        bus.stall_i    = 0;
        bus.flush_i    = 0;
        bus.data_resp  = 0;
        bus.data_rdata = 0;

        #3 check_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;

        // Non-load, one-cycle latency
        drive(1, 0, 32'h0000_1235, 32'h0000_006C, 21'h1A5A5);
        tick();
        check("nl.valid", bus.out_valid, 1);
        check("nl.alu",   bus.out_alu, 32'h1235);
        check("nl.pc",    bus.out_pc, 32'h6C);
        check("nl.ctrl",  bus.out_ctrl, 21'h1A5A5);
        check("nl.br",    bus.out_br_en, 1);
        check("nl.ben",   bus.out_mem_byte_en, 4'hC);
        check("nl.busy",  bus.busy_o, 0);

        // Load with response three cycles late
        drive(1, 1, 32'h0000_0100, 32'h0000_0064, 21'h0F0F0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("ld.busy",  bus.busy_o, 1);
            check("ld.valid", bus.out_valid, 0);
            check("ld.ctrl",  bus.out_ctrl, 0);
            if (i < 2) tick();
        end
        bus.data_resp  = 1;
        bus.data_rdata = 32'hDEAD_BEEF;
        #1 check("ld.spur", bus.spurious_resp_o, 0);
        tick();
        bus.data_resp = 0;
        check("ld.valid2", bus.out_valid, 1);
        check("ld.data",   bus.out_data, 32'hDEAD_BEEF);
        check("ld.alu",    bus.out_alu, 32'h100);
        check("ld.ctrl2",  bus.out_ctrl, 21'h0F0F0);
        check("ld.busy2",  bus.busy_o, 0);

        // Flush during WAIT, response drained
        drive(1, 1, 32'h0000_0200, 32'h0000_0068, 21'h00333);
        tick();
        drive(0, 0, 0, 0, 0);
        check("fl.wait", bus.busy_o, 1);
        bus.flush_i = 1;
        tick();
        bus.flush_i = 0;
        check("fl.drain_busy",  bus.busy_o, 1);
        check("fl.drain_valid", bus.out_valid, 0);
        bus.data_resp  = 1;
        bus.data_rdata = 32'hCAFE_F00D;
        #1 check("fl.spur", bus.spurious_resp_o, 0);
        tick();
        bus.data_resp = 0;
        check("fl.data",  bus.out_data, 32'hDEAD_BEEF);
        check("fl.busy",  bus.busy_o, 0);
        check("fl.valid", bus.out_valid, 0);

        // Stall with FULL slot while in_* changes
        drive(1, 0, 32'h0000_00A1, 32'h0000_0070, 21'h01111);
        tick();
        bus.stall_i = 1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'h0000_00B0 + i, 32'h0000_0080 + 4 * i, 21'h02222);
            tick();
            check("st.alu",   bus.out_alu, 32'hA1);
            check("st.pc",    bus.out_pc, 32'h70);
            check("st.valid", bus.out_valid, 1);
            check("st.ctrl",  bus.out_ctrl, 21'h01111);
        end
        drive(1, 0, 32'h0000_00C5, 32'h0000_0074, 21'h04444);
        bus.stall_i = 0;
        tick();
        check("st.alu2",  bus.out_alu, 32'hC5);
        check("st.pc2",   bus.out_pc, 32'h74);
        check("st.ctrl2", bus.out_ctrl, 21'h04444);

        // Flush + stall + in_valid together
        drive(1, 0, 32'h0000_00D0, 32'h0000_0078, 21'h05555);
        bus.stall_i = 1;
        bus.flush_i = 1;
        tick();
        bus.stall_i = 0;
        bus.flush_i = 0;
        check("fs.valid", bus.out_valid, 0);
        check("fs.ctrl",  bus.out_ctrl, 0);

        // Response with a non-load being accepted is spurious and ignored
        drive(1, 0, 32'h0000_00E0, 32'h0000_007C, 21'h06666);
        bus.data_resp  = 1;
        bus.data_rdata = 32'h5555_AAAA;
        #1 check("sp.pulse", bus.spurious_resp_o, 1);
        tick();
        bus.data_resp = 0;
        #1 check("sp.low",  bus.spurious_resp_o, 0);
        check("sp.data",    bus.out_data, 32'hDEAD_BEEF);
        check("sp.valid",   bus.out_valid, 1);

        // Load with same-cycle response: one-cycle latency
        drive(1, 1, 32'h0000_00F0, 32'h0000_0040, 21'h07777);
        bus.data_resp  = 1;
        bus.data_rdata = 32'h1111_2222;
        #1 check("sc.spur", bus.spurious_resp_o, 0);
        tick();
        bus.data_resp = 0;
        check("sc.valid", bus.out_valid, 1);
        check("sc.data",  bus.out_data, 32'h1111_2222);
        check("sc.busy",  bus.busy_o, 0);

        // Flush and response together in WAIT: data dropped, straight to EMPTY
        drive(1, 1, 32'h0000_0300, 32'h0000_0044, 21'h08888);
        tick();
        drive(0, 0, 0, 0, 0);
        check("fr.wait", bus.busy_o, 1);
        bus.flush_i    = 1;
        bus.data_resp  = 1;
        bus.data_rdata = 32'h3333_3333;
        #1 check("fr.spur", bus.spurious_resp_o, 0);
        tick();
        bus.flush_i   = 0;
        bus.data_resp = 0;
        check("fr.busy",  bus.busy_o, 0);
        check("fr.valid", bus.out_valid, 0);
        check("fr.data",  bus.out_data, 32'h1111_2222);

        // Reset mid-WAIT
        drive(1, 1, 32'h0000_0400, 32'h0000_0048, 21'h09999);
        tick();
        drive(0, 0, 0, 0, 0);
        check("rw.wait", bus.busy_o, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rw");
        tick();
        rst_n = 1'b1;
        bus.data_resp  = 1;
        bus.data_rdata = 32'h7777_7777;
        #1 check("rw.spur", bus.spurious_resp_o, 1);
        tick();
        bus.data_resp = 0;
        check("rw.data", bus.out_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sreg_mem_wb_ctl.md
# sreg_mem_wb_ctl

Parametrised, flow-controlled MEM/WB pipeline stage register and the next generation of the plain MEM/WB latch. It adds a per-stage valid bit, stall and flush, and a load-response tracker. The tracker holds a load in the stage until its memory response arrives, and it drains responses for loads that were flushed. It sits between the MEM stage (data-cache port) and writeback. Invalid slots present a zeroed control word, so writeback never commits a bubble.

## Interface
- `DATA_W`, 32, width of ALU result, PC and load data.
- `CTRL_W`, `$bits(rv32i_control_word)`, packed control-word width.
- `MASK_W`, `DATA_W/8`, byte-enable width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  MEM slot holds a real instruction.
- `in_is_load`  in  1  instruction needs `data_rdata`.
- `in_alu`, `in_pc`  in  DATA_W  ALU result and PC.
- `in_ctrl`  in  CTRL_W  control word.
- `in_br_en`  in  1  branch-enable.
- `in_mem_byte_en`  in  MASK_W  byte enables.
- `stall_i`  in  1  hold the stage; no capture of the in_* bundle.
- `flush_i`  in  1  kill the held slot and the incoming slot.
- `data_resp`  in  1  single-cycle memory response strobe.
- `data_rdata`  in  DATA_W  response data, valid with `data_resp`.
- `out_valid`  out  1  writeback slot valid.
- `out_alu`, `out_pc`, `out_data`  out  DATA_W  held payload.
- `out_ctrl`  out  CTRL_W  held control word when `out_valid`, otherwise `'0`.
- `out_br_en`  out  1.
- `out_mem_byte_en`  out  MASK_W.
- `busy_o`  out  1  stage is waiting on memory; upstream must stall.
- `spurious_resp_o`  out  1  one-cycle pulse when a response arrives with no load outstanding.

## Operation
- States: EMPTY, FULL, WAIT (valid load, response pending), DRAIN (flushed load, response pending).
- `busy_o` = state ∈ {WAIT, DRAIN}.
- `adv` = !stall_i & !busy_o & !flush_i.
- EMPTY/FULL with `adv`:
  - capture the in_* bundle.
  - Next state is EMPTY if !in_valid.
  - Next state is FULL if in_valid & (!in_is_load | data_resp); data is captured from `data_rdata` when `data_resp`.
  - Next state is WAIT otherwise.
- EMPTY/FULL with `stall_i` and no flush: hold all registers and state.
- WAIT:
  - `data_resp` captures `data_rdata` and moves to FULL, regardless of `stall_i`.
  - Otherwise hold.
- DRAIN:
  - `data_resp` is discarded and moves to EMPTY.
  - `flush_i` is ignored.
- `flush_i`:
  - From EMPTY/FULL, go to EMPTY and drop the incoming slot.
  - From WAIT, go to DRAIN.
  - A response in the same cycle as a flush from WAIT discards the data and goes straight to EMPTY.
  - Flush beats stall.
- `out_valid` = (state == FULL).
- `out_data` changes only on an accepted response. It otherwise retains its last captured value.
- `spurious_resp_o` pulses when `data_resp` arrives in EMPTY/FULL and is not consumed by a load being accepted that cycle. The data is ignored in that case.

## Timing
- Reset (async assert, sync release): state EMPTY, every payload register 0.
- Resulting outputs: `out_valid`, `out_ctrl`, `busy_o`, `spurious_resp_o` all 0, and every other output 0.
- Latency: 1 cycle, in_* to out_* for non-loads and same-cycle-response loads.
- A load with a response k cycles after capture appears k cycles later than a non-load.
- `busy_o` is Moore, decoded from registered state. It rises the cycle after a load enters without a response.
- `out_ctrl` gating and `spurious_resp_o` are combinational from registered state and inputs. No other output has a combinational path.

## Structure
- `mem_wb_state_e` (EMPTY/FULL/WAIT/DRAIN) goes in `rv32i_types` next to `rv32i_control_word`.
- Sub-module `mem_resp_tracker` holds the 4-state FSM. Inputs: accept/is_load/resp/flush. Outputs: state, `busy_o`, capture-enable, `spurious_resp_o`.
- The top level holds the payload registers and the output gating.

## Test plan
- Reset mid-WAIT: deassert `rst_n` in WAIT -> all outputs 0 immediately and state EMPTY; a later `data_resp` gives `spurious_resp_o` = 1.
- Non-load: in_valid = 1, in_alu = 0x0000_1234, in_pc = 0x60 -> next cycle out_valid = 1, out_alu = 0x1234, out_pc = 0x60, out_ctrl = in_ctrl.
- Load, response 3 cycles late, data 0xDEAD_BEEF -> busy_o high for 3 cycles, out_valid = 0 throughout; then out_valid = 1, out_data = 0xDEAD_BEEF, busy_o = 0.
- Flush during WAIT, then response 0xCAFE_F00D -> DRAIN, out_valid = 0; response discarded, out_data unchanged, state EMPTY, busy_o = 0.
- Stall with FULL slot for 4 cycles while in_* changes -> outputs constant; first unstalled cycle captures current in_*.
- Flush + stall + in_valid in one cycle -> next cycle out_valid = 0, out_ctrl = 0.
